gray_codec_pipe: RTL

Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshakes on both sides. Each transaction carries its own direction bit, so one instance serves pointer encoding (binary to Gray) and decoding (Gray to binary) in FIFO and CDC paths. Results leave in order after a fixed latency, with full backpressure and no data loss. An optional checker flags Gray inputs that break the one-bit-change rule.

---
 rtl/gray_codec_pkg.sv | 35 +++
 rtl/gray_codec_stage.sv | 38 +++
 rtl/gray_codec_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gray_codec_pkg.sv
// Shared constants and conversion helpers for the Gray/binary codec pipe.
// Helpers operate on MAX_WIDTH-bit words. Callers zero-extend narrower words on the way in
// and truncate on the way out. Leading zeros do not change either conversion, so this is exact.
// Any user of the helpers must keep WIDTH <= MAX_WIDTH.
package gray_codec_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  localparam int MAX_WIDTH = 32;

  // Binary bit i is the XOR of all Gray bits at and above i (running prefix from the MSB).
  function automatic logic [MAX_WIDTH-1:0] g2b(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] b2g(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] x);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + 32'(x[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One register slice of the codec pipe: valid, mode, data, err.
// Ports: clk/rst; load (take the upstream slot this cycle), up_* (upstream slot contents),
//        valid/mode/data/err (held slot contents).
// A load carrying a bubble only clears valid. The payload keeps its last value,
// so the outputs do not toggle needlessly.
module gray_codec_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_err,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        mode <= up_mode;
        data <= up_data;
        err  <= up_err;
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional Gray<->binary converter with valid/ready handshakes on both sides.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_mode/in_data (input side);
//        out_valid/out_ready/out_mode/out_data/out_err (output side); err_cnt (flag counter).
// Latency is STAGES register slices. Ready ripples combinationally back from out_ready,
// so a full pipe still accepts a word on any cycle it drains one.
// Optional macro GRAY_CODEC_ADJ_CHECK_EN flags mode-0 inputs whose Hamming distance from
// the previous mode-0 input exceeds 1.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] md;
  logic [STAGES-1:0] er;
  logic [WIDTH-1:0]  dt [STAGES];
  // rdy[k]: slice k may load this cycle. rdy[STAGES] is the downstream consumer.
  logic [STAGES:0]   rdy;

  logic [WIDTH-1:0]  conv;
  logic              err_in;

  // The chain is built in one block, walking from the output back toward the input.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  assign conv = (in_mode == MODE_G2B) ? WIDTH'(g2b(MAX_WIDTH'(in_data)))
                                      : WIDTH'(b2g(MAX_WIDTH'(in_data)));

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_head
      gray_codec_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (rdy[0]),
        .up_valid (in_valid),
        .up_mode  (in_mode),
        .up_data  (conv),
        .up_err   (err_in),
        .valid    (v[0]),
        .mode     (md[0]),
        .data     (dt[0]),
        .err      (er[0])
      );
    end else begin : g_body
      gray_codec_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (rdy[k]),
        .up_valid (v[k-1]),
        .up_mode  (md[k-1]),
        .up_data  (dt[k-1]),
        .up_err   (er[k-1]),
        .valid    (v[k]),
        .mode     (md[k]),
        .data     (dt[k]),
        .err      (er[k])
      );
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_mode  = md[STAGES-1];
  assign out_data  = dt[STAGES-1];
  assign out_err   = er[STAGES-1];

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic             accept;
  logic [WIDTH-1:0] hist;
  logic             hist_vld;
  logic [7:0]       cnt;

  assign accept = in_valid && in_ready;

  // hist_vld keeps the first mode-0 word after reset from being compared
  // against the cleared history.
  assign err_in = (in_mode == MODE_G2B) && hist_vld &&
                  (popcount(MAX_WIDTH'(in_data ^ hist)) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      hist_vld <= 1'b0;
      cnt      <= 8'd0;
    end else if (accept) begin
      if (in_mode == MODE_G2B) begin
        hist     <= in_data;
        hist_vld <= 1'b1;
      end
      if (err_in && (cnt != 8'hff)) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign err_cnt = cnt;
`else
  assign err_in  = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule
